// File: rtl/cl_ocl_regs.sv
// AXI4-Lite register file on the shell's OCL BAR: ID, scratch, byte-swapped hello,
// virtual LEDs, cycle counter and decode-error counter. Define CL_OCL_WSTRB_EN for per-byte write strobes.
module cl_ocl_regs #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] ID_VAL    = 32'hF000_1D0F,
    parameter int          ERR_CNT_W = 16
) (
    input  logic              clk_main_a0,
    input  logic              rst_main_sync,
    input  logic [ADDR_W-1:0] sh_ocl_awaddr,
    input  logic              sh_ocl_awvalid,
    output logic              ocl_sh_awready,
    input  logic [31:0]       sh_ocl_wdata,
    input  logic [3:0]        sh_ocl_wstrb,
    input  logic              sh_ocl_wvalid,
    output logic              ocl_sh_wready,
    output logic [1:0]        ocl_sh_bresp,
    output logic              ocl_sh_bvalid,
    input  logic              sh_ocl_bready,
    input  logic [ADDR_W-1:0] sh_ocl_araddr,
    input  logic              sh_ocl_arvalid,
    output logic              ocl_sh_arready,
    output logic [31:0]       ocl_sh_rdata,
    output logic [1:0]        ocl_sh_rresp,
    output logic              ocl_sh_rvalid,
    input  logic              sh_ocl_rready,
    output logic [15:0]       cl_vled
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_A, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    wr_state_t             wr_state;
    rd_state_t             rd_state;
    logic [ADDR_W-1:0]     aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;

    logic [31:0]           scratch;
    logic [31:0]           hello;
    logic [15:0]           vled;
    logic [31:0]           cycle_cnt;
    logic [ERR_CNT_W-1:0]  err_cnt;

    // Effective write beat: whichever half arrived earlier comes from the latch.
    logic                  wr_commit;
    logic [ADDR_W-1:0]     wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic [31:0]           wr_mask;
    logic [5:0]            wr_off;
    logic                  wr_ok;
    logic                  wr_err;
    logic                  err_clr;
    logic [1:0]            wr_resp;

    always_comb begin
        case (wr_state)
            WR_IDLE:   wr_commit = sh_ocl_awvalid && sh_ocl_wvalid;
            WR_WAIT_W: wr_commit = sh_ocl_wvalid;
            WR_WAIT_A: wr_commit = sh_ocl_awvalid;
            default:   wr_commit = 1'b0;
        endcase
    end

    assign wr_addr = (wr_state == WR_WAIT_W) ? aw_addr_q : sh_ocl_awaddr;
    assign wr_data = (wr_state == WR_WAIT_A) ? w_data_q : sh_ocl_wdata;
    assign wr_strb = (wr_state == WR_WAIT_A) ? w_strb_q : sh_ocl_wstrb;
    assign wr_off  = wr_addr[7:2];
    assign wr_ok   = (wr_addr[ADDR_W-1:8] == '0) &&
                     (wr_off == 6'd1 || wr_off == 6'd2 || wr_off == 6'd3 || wr_off == 6'd5);
    assign wr_err  = wr_commit && !wr_ok;
    assign err_clr = wr_commit && wr_ok && (wr_off == 6'd5);
    assign wr_resp = wr_ok ? RESP_OKAY : RESP_SLVERR;

`ifdef CL_OCL_WSTRB_EN
    assign wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
`else
    logic unused_strb;
    assign unused_strb = &{1'b0, wr_strb};
    assign wr_mask     = '1;
`endif

    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, wr_addr[1:0], sh_ocl_araddr[1:0]};

    // Read decode from the current (pre-write) register state.
    logic [5:0]  rd_off;
    logic        rd_hs;
    logic        rd_err;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    assign rd_off = sh_ocl_araddr[7:2];
    assign rd_hs  = (rd_state == RD_IDLE) && sh_ocl_arvalid;
    assign rd_err = rd_hs && (rd_resp == RESP_SLVERR);

    always_comb begin
        rd_data = ERR_DATA;
        rd_resp = RESP_SLVERR;
        if (sh_ocl_araddr[ADDR_W-1:8] == '0) begin
            rd_resp = RESP_OKAY;
            case (rd_off)
                6'd0: rd_data = ID_VAL;
                6'd1: rd_data = scratch;
                6'd2: rd_data = {hello[7:0], hello[15:8], hello[23:16], hello[31:24]};
                6'd3: rd_data = {16'h0, vled};
                6'd4: rd_data = cycle_cnt;
                6'd5: begin
                    rd_data = '0;
                    rd_data[ERR_CNT_W-1:0] = err_cnt;
                end
                default: begin
                    rd_data = ERR_DATA;
                    rd_resp = RESP_SLVERR;
                end
            endcase
        end
    end

    // Up to two errors per cycle (one read, one write); widen by a bit to catch saturation.
    logic [ERR_CNT_W:0] err_sum;
    assign err_sum = {1'b0, err_cnt} + (ERR_CNT_W + 1)'({1'b0, rd_err} + {1'b0, wr_err});

    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            wr_state       <= WR_IDLE;
            ocl_sh_awready <= 1'b1;
            ocl_sh_wready  <= 1'b1;
            ocl_sh_bvalid  <= 1'b0;
            ocl_sh_bresp   <= RESP_OKAY;
            aw_addr_q      <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (wr_commit) begin
                        wr_state       <= WR_RESP;
                        ocl_sh_awready <= 1'b0;
                        ocl_sh_wready  <= 1'b0;
                        ocl_sh_bvalid  <= 1'b1;
                        ocl_sh_bresp   <= wr_resp;
                    end else if (sh_ocl_awvalid) begin
                        wr_state       <= WR_WAIT_W;
                        ocl_sh_awready <= 1'b0;
                        aw_addr_q      <= sh_ocl_awaddr;
                    end else if (sh_ocl_wvalid) begin
                        wr_state       <= WR_WAIT_A;
                        ocl_sh_wready  <= 1'b0;
                        w_data_q       <= sh_ocl_wdata;
                        w_strb_q       <= sh_ocl_wstrb;
                    end
                end
                WR_WAIT_W, WR_WAIT_A: begin
                    if (wr_commit) begin
                        wr_state       <= WR_RESP;
                        ocl_sh_awready <= 1'b0;
                        ocl_sh_wready  <= 1'b0;
                        ocl_sh_bvalid  <= 1'b1;
                        ocl_sh_bresp   <= wr_resp;
                    end
                end
                WR_RESP: begin
                    if (sh_ocl_bready) begin
                        wr_state       <= WR_IDLE;
                        ocl_sh_awready <= 1'b1;
                        ocl_sh_wready  <= 1'b1;
                        ocl_sh_bvalid  <= 1'b0;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            rd_state       <= RD_IDLE;
            ocl_sh_arready <= 1'b1;
            ocl_sh_rvalid  <= 1'b0;
            ocl_sh_rdata   <= '0;
            ocl_sh_rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (rd_hs) begin
                        rd_state       <= RD_RESP;
                        ocl_sh_arready <= 1'b0;
                        ocl_sh_rvalid  <= 1'b1;
                        ocl_sh_rdata   <= rd_data;
                        ocl_sh_rresp   <= rd_resp;
                    end
                end
                RD_RESP: begin
                    if (sh_ocl_rready) begin
                        rd_state       <= RD_IDLE;
                        ocl_sh_arready <= 1'b1;
                        ocl_sh_rvalid  <= 1'b0;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            scratch   <= '0;
            hello     <= '0;
            vled      <= '0;
            cycle_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_commit && wr_ok) begin
                case (wr_off)
                    6'd1:    scratch <= (scratch & ~wr_mask) | (wr_data & wr_mask);
                    6'd2:    hello   <= (hello & ~wr_mask) | (wr_data & wr_mask);
                    6'd3:    vled    <= (vled & ~wr_mask[15:0]) | (wr_data[15:0] & wr_mask[15:0]);
                    default: ;
                endcase
            end
            // A clear beats any increment landing in the same cycle.
            if (err_clr)
                err_cnt <= '0;
            else if (err_sum[ERR_CNT_W])
                err_cnt <= '1;
            else
                err_cnt <= err_sum[ERR_CNT_W-1:0];
        end
    end

    assign cl_vled = vled;

endmodule
